// File: rtl/dmem_mmio.sv
// Data memory + MMIO (GPIO, optional timer under DMEM_TIMER_EN); zero-latency combinational reads.
// Writes land on the rising clk edge and are ignored while reset is high; RAM contents survive reset.
module dmem_mmio #(
    parameter int RAM_AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    localparam logic [29:0] A_GPIO_OUT = 30'h400;
    localparam logic [29:0] A_GPIO_IN  = 30'h401;

    logic [29:0]       waddr;
    logic              ram_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    assign waddr            = ALUResult[31:2];
    assign ram_sel          = (ALUResult[31:RAM_AW+2] == '0);
    assign ram_idx          = ALUResult[RAM_AW+1:2];
    assign unused_addr_bits = ^ALUResult[1:0];

    // RAM has no reset so data written before a reset pulse stays readable.
    logic [31:0] mem_q [0:(1<<RAM_AW)-1];

    always_ff @(posedge clk) begin
        if (MemWrite && ram_sel && !reset) begin
            mem_q[ram_idx] <= WriteData;
        end
    end

    logic [7:0] gpio_out_q, gpio_out_d;
    logic [7:0] sync1_q, sync2_q;

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (MemWrite && (waddr == A_GPIO_OUT)) begin
            gpio_out_d = WriteData[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
        end
    end

    assign gpio_out = gpio_out_q;

`ifdef DMEM_TIMER_EN
    localparam logic [29:0] A_TCNT  = 30'h402;
    localparam logic [29:0] A_TCMP  = 30'h403;
    localparam logic [29:0] A_TCTRL = 30'h404;

    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic        en_q, en_d, auto_q, auto_d, pend_q, pend_d, ie_q, ie_d;
    logic        match, wr_tcnt, wr_tcmp, wr_tctrl;

    // Match uses registered EN, so enabling with TCNT==TCMP matches one edge later.
    assign match    = en_q && (tcnt_q == tcmp_q);
    assign wr_tcnt  = MemWrite && (waddr == A_TCNT);
    assign wr_tcmp  = MemWrite && (waddr == A_TCMP);
    assign wr_tctrl = MemWrite && (waddr == A_TCTRL);

    always_comb begin
        tcnt_d = tcnt_q;
        tcmp_d = tcmp_q;
        en_d   = en_q;
        auto_d = auto_q;
        pend_d = pend_q;
        ie_d   = ie_q;
        if (en_q) begin
            if (match) begin
                if (auto_q) begin
                    tcnt_d = '0;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end
        if (wr_tctrl) begin
            en_d   = WriteData[0];
            auto_d = WriteData[1];
            ie_d   = WriteData[3];
            if (WriteData[2]) begin
                pend_d = 1'b0;
            end
        end
        // Hardware set of PEND beats a same-cycle W1C; software TCNT write beats count/reload.
        if (match) begin
            pend_d = 1'b1;
        end
        if (wr_tcmp) begin
            tcmp_d = WriteData;
        end
        if (wr_tcnt) begin
            tcnt_d = WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
            tcmp_q <= '0;
            en_q   <= 1'b0;
            auto_q <= 1'b0;
            pend_q <= 1'b0;
            ie_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tcmp_q <= tcmp_d;
            en_q   <= en_d;
            auto_q <= auto_d;
            pend_q <= pend_d;
            ie_q   <= ie_d;
        end
    end

    assign timer_irq = pend_q & ie_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        ReadData = '0;
        if (ram_sel) begin
            ReadData = mem_q[ram_idx];
        end else begin
            case (waddr)
                A_GPIO_OUT: ReadData = {24'b0, gpio_out_q};
                A_GPIO_IN:  ReadData = {24'b0, sync2_q};
`ifdef DMEM_TIMER_EN
                A_TCNT:     ReadData = tcnt_q;
                A_TCMP:     ReadData = tcmp_q;
                A_TCTRL:    ReadData = {28'b0, ie_q, pend_q, auto_q, en_q};
`endif
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, GPIO, synchronizer, reset and (when built in) the timer.
module tb_dmem_mmio;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    dmem_mmio #(.RAM_AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // All tasks start and end at negedge+1, one posedge per write.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ALUResult = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        MemWrite  = 1'b0;
        ALUResult = a;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (gpio_out !== 8'h00) begin
            failures++;
            $display("FAIL rst_gpio_out: got %h want 00", gpio_out);
        end
        checks++;
        if (timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL rst_irq: got %b want 0", timer_irq);
        end
        rd(32'h1000);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL rst_rd_gpio_out: got %h want 0", ReadData);
        end
        rd(32'h1010);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL rst_rd_tctrl: got %h want 0", ReadData);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_ram();
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0013);
        checks++;
        if (ReadData !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ram_low_bits_ignored: got %h want deadbeef", ReadData);
        end
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h0000_0400, 32'hAAAA_5555);
        rd(32'h0000_0000);
        checks++;
        if (ReadData !== 32'h1111_1111) begin
            failures++;
            $display("FAIL ram_no_alias_400: got %h want 11111111", ReadData);
        end
        rd(32'h0000_0400);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL ram_past_end_unmapped: got %h want 0", ReadData);
        end
        wr(32'h0000_03FC, 32'hCAFE_F00D);
        rd(32'h0000_03FF);
        checks++;
        if (ReadData !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL ram_top_word: got %h want cafef00d", ReadData);
        end
        MemWrite  = 1'b1;
        ALUResult = 32'h0000_0010;
        WriteData = 32'h0123_4567;
        #1;
        checks++;
        if (ReadData !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ram_read_during_write: got %h want deadbeef", ReadData);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        rd(32'h0000_0010);
        checks++;
        if (ReadData !== 32'h0123_4567) begin
            failures++;
            $display("FAIL ram_after_write: got %h want 01234567", ReadData);
        end
    endtask

    task automatic test_gpio();
        wr(32'h1000, 32'h0000_01FF);
        checks++;
        if (gpio_out !== 8'hFF) begin
            failures++;
            $display("FAIL gpio_out_write: got %h want ff", gpio_out);
        end
        rd(32'h1000);
        checks++;
        if (ReadData !== 32'h0000_00FF) begin
            failures++;
            $display("FAIL gpio_out_readback: got %h want 000000ff", ReadData);
        end
        wr(32'h2000, 32'h0000_0123);
        rd(32'h2000);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_2000: got %h want 0", ReadData);
        end
        rd(32'h0000_0000);
        checks++;
        if (ReadData !== 32'h1111_1111) begin
            failures++;
            $display("FAIL unmapped_write_ram_alias: got %h want 11111111", ReadData);
        end
        wr(32'h1004, 32'h0000_0077);
        checks++;
        if (gpio_out !== 8'hFF) begin
            failures++;
            $display("FAIL gpio_in_write_gpio_out: got %h want ff", gpio_out);
        end
        rd(32'h1004);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL gpio_in_write_ignored: got %h want 0", ReadData);
        end
    endtask

    task automatic test_sync();
        rd(32'h1004);
        gpio_in = 8'hA5;
        @(posedge clk);
        #1;
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL sync_edge1: got %h want 0", ReadData);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ReadData !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL sync_edge2: got %h want 000000a5", ReadData);
        end
        @(negedge clk);
        #1;
    endtask

`ifdef DMEM_TIMER_EN
    task automatic test_timer_auto();
        wr(32'h100C, 32'd3);
        wr(32'h1010, 32'hB);
        rd(32'h1008);
        checks++;
        if (ReadData !== 32'd0) begin
            failures++;
            $display("FAIL auto_cnt0: got %0d want 0", ReadData);
        end
        tick();
        tick();
        checks++;
        if (ReadData !== 32'd2) begin
            failures++;
            $display("FAIL auto_cnt2: got %0d want 2", ReadData);
        end
        tick();
        checks++;
        if (ReadData !== 32'd3 || timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL auto_cnt3: got %0d irq %b want 3 irq 0", ReadData, timer_irq);
        end
        tick();
        checks++;
        if (ReadData !== 32'd0 || timer_irq !== 1'b1) begin
            failures++;
            $display("FAIL auto_reload: got %0d irq %b want 0 irq 1", ReadData, timer_irq);
        end
        rd(32'h1010);
        checks++;
        if (ReadData !== 32'hF) begin
            failures++;
            $display("FAIL auto_tctrl: got %h want f", ReadData);
        end
        wr(32'h1010, 32'h4);
        rd(32'h1010);
        checks++;
        if (ReadData !== 32'h0 || timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL auto_w1c: got %h irq %b want 0 irq 0", ReadData, timer_irq);
        end
    endtask

    task automatic test_priority();
        wr(32'h1008, 32'd0);
        wr(32'h100C, 32'd1);
        wr(32'h1010, 32'hB);
        tick();
        tick();
        tick();
        rd(32'h1008);
        checks++;
        if (ReadData !== 32'd1 || timer_irq !== 1'b1) begin
            failures++;
            $display("FAIL prio_setup: got %0d irq %b want 1 irq 1", ReadData, timer_irq);
        end
        wr(32'h1010, 32'hF);
        rd(32'h1010);
        checks++;
        if (ReadData !== 32'hF) begin
            failures++;
            $display("FAIL prio_set_over_w1c: got %h want f", ReadData);
        end
        tick();
        wr(32'h1008, 32'h10);
        rd(32'h1008);
        checks++;
        if (ReadData !== 32'h10) begin
            failures++;
            $display("FAIL prio_sw_tcnt_over_reload: got %h want 10", ReadData);
        end
        wr(32'h1010, 32'h4);
        wr(32'h1008, 32'hFFFF_FFFE);
        wr(32'h100C, 32'd5);
        wr(32'h1010, 32'h1);
        tick();
        tick();
        rd(32'h1008);
        checks++;
        if (ReadData !== 32'd0) begin
            failures++;
            $display("FAIL tcnt_wrap: got %h want 0", ReadData);
        end
        wr(32'h1010, 32'h0);
    endtask

    task automatic test_oneshot();
        wr(32'h1008, 32'd0);
        wr(32'h100C, 32'd2);
        wr(32'h1010, 32'h1);
        tick();
        tick();
        tick();
        rd(32'h1008);
        checks++;
        if (ReadData !== 32'd2) begin
            failures++;
            $display("FAIL oneshot_hold: got %0d want 2", ReadData);
        end
        rd(32'h1010);
        checks++;
        if (ReadData !== 32'h4 || timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_tctrl: got %h irq %b want 4 irq 0", ReadData, timer_irq);
        end
        wr(32'h1010, 32'h4);
        wr(32'h1008, 32'd9);
        wr(32'h100C, 32'd9);
        wr(32'h1010, 32'h1);
        rd(32'h1010);
        checks++;
        if (ReadData !== 32'h1) begin
            failures++;
            $display("FAIL enable_no_match_on_write_edge: got %h want 1", ReadData);
        end
        tick();
        checks++;
        if (ReadData !== 32'h4) begin
            failures++;
            $display("FAIL enable_match_next_edge: got %h want 4", ReadData);
        end
        wr(32'h1010, 32'h4);
    endtask
`else
    task automatic test_no_timer();
        wr(32'h1008, 32'd5);
        rd(32'h1008);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL notimer_tcnt: got %h want 0", ReadData);
        end
        wr(32'h1010, 32'hF);
        rd(32'h1010);
        checks++;
        if (ReadData !== 32'h0 || timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL notimer_tctrl: got %h irq %b want 0 irq 0", ReadData, timer_irq);
        end
    endtask
`endif

    task automatic test_reset_mid();
`ifdef DMEM_TIMER_EN
        wr(32'h1008, 32'd3);
        wr(32'h100C, 32'hFF);
        wr(32'h1010, 32'h1);
        tick();
        tick();
        rd(32'h1008);
        checks++;
        if (ReadData !== 32'd5) begin
            failures++;
            $display("FAIL mid_pre_cnt: got %0d want 5", ReadData);
        end
`endif
        reset = 1'b1;
        #1;
        checks++;
        if (gpio_out !== 8'h00) begin
            failures++;
            $display("FAIL mid_gpio_out: got %h want 00", gpio_out);
        end
        rd(32'h1008);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL mid_tcnt: got %h want 0", ReadData);
        end
        rd(32'h1010);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL mid_tctrl: got %h want 0", ReadData);
        end
        rd(32'h1004);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL mid_sync: got %h want 0", ReadData);
        end
        wr(32'h1000, 32'hFF);
        wr(32'h0000_0010, 32'h0BAD_F00D);
        checks++;
        if (gpio_out !== 8'h00) begin
            failures++;
            $display("FAIL mid_write_ignored: got %h want 00", gpio_out);
        end
        reset = 1'b0;
        rd(32'h0000_0010);
        checks++;
        if (ReadData !== 32'h0123_4567) begin
            failures++;
            $display("FAIL mid_ram_kept: got %h want 01234567", ReadData);
        end
        rd(32'h0000_03FC);
        checks++;
        if (ReadData !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL mid_ram_top_kept: got %h want cafef00d", ReadData);
        end
        rd(32'h1008);
        tick();
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL mid_count_aborted: got %h want 0", ReadData);
        end
    endtask

    initial begin
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        gpio_in   = '0;
        reset     = 1'b1;
        test_reset();
        test_ram();
        test_gpio();
        test_sync();
`ifdef DMEM_TIMER_EN
        test_timer_auto();
        test_priority();
        test_oneshot();
`else
        test_no_timer();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
